// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: state encoding, word width,
// reset PC and the redirect-selection payload.
package mips_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned JIDX_W = 26;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ERROR = 2'd2
  } state_e;

  // Winning redirect for the current cycle
  typedef struct packed {
    logic              redirect;
    logic              misalign;
    logic [WORD_W-1:0] target;
  } redirect_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch handshake between the PC stage and imem.
interface pc_fetch_unit_if;

  logic                        imem_req;
  logic                        imem_ready;
  logic [mips_pkg::WORD_W-1:0] pc_out;

  modport master (output imem_req, output pc_out, input imem_ready);
  modport slave  (input imem_req, input pc_out, output imem_ready);

endinterface

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Combinational redirect-target computation, priority select and
// word-alignment check for the fetch stage.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic              [WORD_W-1:0] pc_plus4,
  input  logic                           branch_taken,
  input  logic              [WORD_W-1:0] branch_offset,
  input  logic                           jump,
  input  logic              [JIDX_W-1:0] jump_index,
  input  logic                           jump_reg,
  input  logic              [WORD_W-1:0] jr_target,
  output redirect_t                      sel_c
);

  logic [WORD_W-1:0] branch_tgt;
  logic [WORD_W-1:0] jump_tgt;

  // Offset is in words; the top two bits fall off the shift (mod 2^32)
  assign branch_tgt = pc_plus4 + {branch_offset[WORD_W-3:0], 2'b00};
  assign jump_tgt   = {pc_plus4[WORD_W-1:WORD_W-4], jump_index, 2'b00};

  always_comb begin
    sel_c = '0;
    if (jump_reg) begin
      sel_c.redirect = 1'b1;
      sel_c.target   = jr_target;
    end else if (jump) begin
      sel_c.redirect = 1'b1;
      sel_c.target   = jump_tgt;
    end else if (branch_taken) begin
      sel_c.redirect = 1'b1;
      sel_c.target   = branch_tgt;
    end
    sel_c.misalign = sel_c.redirect && (sel_c.target[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, fetch FSM and pending-redirect buffer for the
// single-cycle MIPS datapath.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORD_W-1:0]   pc_plus4_in,
  input  logic                branch_taken,
  input  logic [WORD_W-1:0]   branch_offset,
  input  logic                jump,
  input  logic [JIDX_W-1:0]   jump_index,
  input  logic                jump_reg,
  input  logic [WORD_W-1:0]   jr_target,
  input  logic                stall,
  pc_fetch_unit_if.master     imem,
  output logic                misalign_err
);

  state_e            state, state_next;
  logic [WORD_W-1:0] pc, pc_next;
  logic              pend_valid, pend_valid_next;
  logic [WORD_W-1:0] pend_target, pend_target_next;
  logic              req;
  logic              advance;
  redirect_t         sel;

  next_pc_sel u_sel (
    .pc_plus4      (pc_plus4_in),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .jr_target     (jr_target),
    .sel_c         (sel)
  );

  assign advance      = (state == FETCH) && imem.imem_ready && !stall;
  assign imem.pc_out   = pc;
  assign imem.imem_req = req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      pend_valid   <= 1'b0;
      pend_target  <= '0;
      req          <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      pend_valid   <= pend_valid_next;
      pend_target  <= pend_target_next;
      req          <= (state_next == FETCH);
      misalign_err <= (state_next == ERROR);
    end
  end

  // Redirects are only accepted in FETCH; a misaligned one traps before touching PC/pending
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;
    unique case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (sel.redirect && sel.misalign) begin
          state_next = ERROR;
        end else if (advance) begin
          pend_valid_next = 1'b0;
          if (sel.redirect)    pc_next = sel.target;
          else if (pend_valid) pc_next = pend_target;
          else                 pc_next = pc_plus4_in;
        end else if (sel.redirect) begin
          pend_valid_next  = 1'b1;
          pend_target_next = sel.target;
        end
      end
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_plus4_in;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic        jump_reg;
  logic [31:0] jr_target;
  logic        stall;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_plus4_in   (pc_plus4_in),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .jr_target     (jr_target),
    .stall         (stall),
    .imem          (bus.master),
    .misalign_err  (misalign_err)
  );

  // Stand-in for adder_plus4
  assign pc_plus4_in = bus.pc_out + 32'd4;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start;
    logic        br;
    logic [31:0] off;
    logic        j;
    logic [25:0] ji;
    logic        jr;
    logic [31:0] jrt;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_pulses();
    branch_taken = 1'b0;
    jump         = 1'b0;
    jump_reg     = 1'b0;
  endtask

  // Park the PC at a known value via a jump-register redirect
  task automatic goto(input logic [31:0] target);
    jump_reg  = 1'b1;
    jr_target = target;
    tick();
    clear_pulses();
    check("goto_pc", bus.pc_out, target);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0,       1'b0, 32'h0,  32'h0000_00F4};
    vecs[1] = '{32'hFFFF_FFFC, 1'b1, 32'h0,        1'b0, 26'h0,       1'b0, 32'h0,  32'h0000_0000};
    vecs[2] = '{32'h1000_0010, 1'b0, 32'h0,        1'b1, 26'h10,      1'b1, 32'h40, 32'h0000_0040};
    vecs[3] = '{32'h1000_0010, 1'b0, 32'h0,        1'b1, 26'h10,      1'b0, 32'h0,  32'h1000_0040};
    vecs[4] = '{32'h0000_0200, 1'b1, 32'h5,        1'b1, 26'h30,      1'b0, 32'h0,  32'h0000_00C0};
    vecs[5] = '{32'h0000_0200, 1'b1, 32'h5,        1'b0, 26'h0,       1'b0, 32'h0,  32'h0000_0218};
    vecs[6] = '{32'hF000_0000, 1'b0, 32'h0,        1'b1, 26'h3FF_FFFF, 1'b0, 32'h0,  32'hFFFF_FFFC};
    vecs[7] = '{32'h0000_0300, 1'b0, 32'h0,        1'b0, 26'h0,       1'b0, 32'h0,  32'h0000_0304};

    rst_n = 1'b0;
    clear_pulses();
    branch_offset  = '0;
    jump_index     = '0;
    jr_target      = '0;
    stall          = 1'b0;
    bus.imem_ready = 1'b1;

    // Reset state and sequential fetch
    tick();
    check("rst_pc", bus.pc_out, 32'h0);
    check("rst_req", 32'(bus.imem_req), 32'h0);
    check("rst_err", 32'(misalign_err), 32'h0);
    rst_n = 1'b1;
    tick();
    check("idle_exit_req", 32'(bus.imem_req), 32'h1);
    check("idle_exit_pc", bus.pc_out, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq_pc", bus.pc_out, 32'(i * 4));
    end

    // Table of single-cycle redirects
    for (int i = 0; i < 8; i++) begin
      goto(vecs[i].start);
      branch_taken  = vecs[i].br;
      branch_offset = vecs[i].off;
      jump          = vecs[i].j;
      jump_index    = vecs[i].ji;
      jump_reg      = vecs[i].jr;
      jr_target     = vecs[i].jrt;
      tick();
      clear_pulses();
      check($sformatf("vec%0d_pc", i), bus.pc_out, vecs[i].exp_pc);
    end

    // Redirect buffered while imem not ready
    goto(32'h20);
    bus.imem_ready = 1'b0;
    jump       = 1'b1;
    jump_index = 26'h20;
    tick();
    clear_pulses();
    check("hold_pc0", bus.pc_out, 32'h20);
    tick();
    check("hold_pc1", bus.pc_out, 32'h20);
    tick();
    check("hold_pc2", bus.pc_out, 32'h20);
    bus.imem_ready = 1'b1;
    tick();
    check("pend_apply", bus.pc_out, 32'h80);
    tick();
    check("pend_after", bus.pc_out, 32'h84);

    // Stall holds PC with request still asserted
    stall = 1'b1;
    tick();
    check("stall_pc", bus.pc_out, 32'h84);
    check("stall_req", 32'(bus.imem_req), 32'h1);
    stall = 1'b0;
    tick();
    check("unstall_pc", bus.pc_out, 32'h88);

    // Later pending redirect overwrites an earlier one
    stall      = 1'b1;
    jump       = 1'b1;
    jump_index = 26'h40;
    tick();
    clear_pulses();
    jump_reg  = 1'b1;
    jr_target = 32'h300;
    tick();
    clear_pulses();
    check("lastwin_hold", bus.pc_out, 32'h88);
    stall = 1'b0;
    tick();
    check("lastwin_pc", bus.pc_out, 32'h300);

    // Reset mid-wait discards the pending redirect
    bus.imem_ready = 1'b0;
    jump       = 1'b1;
    jump_index = 26'h50;
    tick();
    clear_pulses();
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", bus.pc_out, 32'h0);
    bus.imem_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("rerun_req", 32'(bus.imem_req), 32'h1);
    tick();
    check("no_stale_pc1", bus.pc_out, 32'h4);
    tick();
    check("no_stale_pc2", bus.pc_out, 32'h8);

    // Misaligned jump-register traps and freezes
    jump_reg  = 1'b1;
    jr_target = 32'h42;
    tick();
    clear_pulses();
    check("mis_err", 32'(misalign_err), 32'h1);
    check("mis_req", 32'(bus.imem_req), 32'h0);
    check("mis_pc", bus.pc_out, 32'h8);
    for (int i = 0; i < 10; i++) begin
      branch_taken  = i[0];
      branch_offset = 32'h10;
      tick();
      clear_pulses();
      check("frozen_pc", bus.pc_out, 32'h8);
      check("sticky_err", 32'(misalign_err), 32'h1);
    end
    rst_n = 1'b0;
    #1;
    check("err_cleared", 32'(misalign_err), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("post_err_pc", bus.pc_out, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
